led_scan_controller: RTL and testbench

Time-multiplexes one shared hex-to-seven-segment decoder across DIGITS common-cathode digits on the board display.
- Holds a double-buffered frame of hex nibbles, decimal points and per-digit enables.
- Scans the digits with a blanking gap between them to suppress ghosting.
- Drives the decoder's 4-bit hex input and registers the decoder's 7-bit segment result onto the pins.
- Host logic loads new frames through a valid/ready handshake; each new frame takes effect only at a frame boundary.

---
 rtl/led_scan_controller.sv | 120 ++++++++++++
 tb/tb_led_scan_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// Scans DIGITS common-cathode digits through one shared hex-to-7-segment decoder.
// Frames arrive via valid/ready into a shadow buffer and go live at the next frame boundary.
module led_scan_controller #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*DIGITS-1:0] load_hex,
    input  logic [DIGITS-1:0]   load_dp,
    input  logic [DIGITS-1:0]   load_en,
    output logic [3:0]          dec_hex,
    input  logic [6:0]          dec_segments,
    output logic [6:0]          seg_out,
    output logic                dp_out,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                frame_start
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic              pending;
    logic [3:0]        active_hex [DIGITS];
    logic [3:0]        shadow_hex [DIGITS];
    logic [DIGITS-1:0] active_dp;
    logic [DIGITS-1:0] active_en;
    logic [DIGITS-1:0] shadow_dp;
    logic [DIGITS-1:0] shadow_en;

    logic              slot_end;
    logic              frame_end;
    logic              swap;
    logic              xfer;
    logic              show;
    logic [IW-1:0]     idx_next;
    logic [3:0]        next_hex;

    // Slot/frame boundary decode; the decoder is fed from the frame that will be live next slot
    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        swap      = frame_end && pending;
        xfer      = load_valid && load_ready;
        show      = (cnt >= BLANK_END);
        idx_next  = frame_end ? '0 : idx + IW'(1);
        next_hex  = swap ? shadow_hex[idx_next] : active_hex[idx_next];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            load_ready  <= 1'b1;
            active_dp   <= '0;
            active_en   <= '0;
            shadow_dp   <= '0;
            shadow_en   <= '0;
            dec_hex     <= '0;
            seg_out     <= '0;
            dp_out      <= 1'b0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                active_hex[i] <= '0;
                shadow_hex[i] <= '0;
            end
        end else begin
            if (slot_end) begin
                cnt     <= '0;
                idx     <= idx_next;
                dec_hex <= next_hex;
            end else begin
                cnt <= cnt + CW'(1);
            end

            frame_start <= frame_end;

            // Pins follow the current phase one cycle later; disabled digits stay dark
            if (show && active_en[idx]) begin
                digit_sel <= DIGITS'(1) << idx;
                seg_out   <= dec_segments;
                dp_out    <= active_dp[idx];
            end else begin
                digit_sel <= '0;
                seg_out   <= '0;
                dp_out    <= 1'b0;
            end

            // Swap needs pending=1 and transfer needs ready=1, so they never coincide
            if (swap) begin
                active_dp  <= shadow_dp;
                active_en  <= shadow_en;
                pending    <= 1'b0;
                load_ready <= 1'b1;
                for (int i = 0; i < int'(DIGITS); i++) begin
                    active_hex[i] <= shadow_hex[i];
                end
            end else if (xfer) begin
                shadow_dp  <= load_dp;
                shadow_en  <= load_en;
                pending    <= 1'b1;
                load_ready <= 1'b0;
                for (int i = 0; i < int'(DIGITS); i++) begin
                    shadow_hex[i] <= load_hex[4*i +: 4];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_scan_controller.sv
// Self-checking bench for led_scan_controller (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2).
// Loaded frames are queued with their predicted go-live cycle and popped when the scan reaches it.
module tb_led_scan_controller;

    localparam int DIGITS       = 4;
    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME        = DIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_hex = '0;
    logic [3:0]  load_dp = '0;
    logic [3:0]  load_en = '0;
    logic [3:0]  dec_hex;
    logic [6:0]  dec_segments;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  digit_sel;
    logic        frame_start;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  en;
        int          start;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    frame_t prev;
    int     tn;
    int     errors = 0;
    int     checks = 0;

    always #5 clk = ~clk;

    led_scan_controller #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_hex(load_hex), .load_dp(load_dp), .load_en(load_en),
        .dec_hex(dec_hex), .dec_segments(dec_segments), .seg_out(seg_out),
        .dp_out(dp_out), .digit_sel(digit_sel), .frame_start(frame_start)
    );

    // Shared decoder model, bit0=a .. bit6=g
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    assign dec_segments = seg7(dec_hex);

    // Expected pins at cycle tn reflect the scan position of cycle tn-1
    function automatic logic [3:0] x_sel();
        int m, c, d;
        if (tn == 0) return 4'b0;
        m = tn - 1; c = m % CLK_DIV; d = (m / CLK_DIV) % DIGITS;
        if (c >= BLANK_CYCLES && prev.en[d]) return 4'(1 << d);
        return 4'b0;
    endfunction

    function automatic logic [6:0] x_seg();
        int m, c, d;
        logic [3:0] h;
        if (tn == 0) return 7'b0;
        m = tn - 1; c = m % CLK_DIV; d = (m / CLK_DIV) % DIGITS;
        h = prev.hex[4*d +: 4];
        if (c >= BLANK_CYCLES && prev.en[d]) return seg7(h);
        return 7'b0;
    endfunction

    function automatic logic x_dp();
        int m, c, d;
        if (tn == 0) return 1'b0;
        m = tn - 1; c = m % CLK_DIV; d = (m / CLK_DIV) % DIGITS;
        return (c >= BLANK_CYCLES && prev.en[d]) ? prev.dp[d] : 1'b0;
    endfunction

    function automatic logic [3:0] x_hex();
        int d;
        d = (tn / CLK_DIV) % DIGITS;
        return cur.hex[4*d +: 4];
    endfunction

    function automatic logic x_fs();
        return (tn > 0) && (tn % FRAME == 0);
    endfunction

    function automatic logic x_rdy();
        return exp_q.size() == 0;
    endfunction

    // Advance one clock; a transfer pushes the frame with its go-live cycle
    task automatic step();
        frame_t f;
        if (load_valid && exp_q.size() == 0) begin
            f.hex = load_hex; f.dp = load_dp; f.en = load_en;
            f.start = FRAME * ((tn + 1) / FRAME + 1);
            exp_q.push_back(f);
        end
        @(posedge clk);
        #1;
        tn++;
        prev = cur;
        if (exp_q.size() > 0 && exp_q[0].start == tn) cur = exp_q.pop_front();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        load_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        tn = 0;
        cur = '{hex: 16'h0, dp: 4'h0, en: 4'h0, start: 0};
        prev = cur;
        exp_q.delete();
    endtask

    task automatic load_frame(input logic [15:0] h, input logic [3:0] dp,
                              input logic [3:0] en, output int st);
        bit done;
        done = 1'b0;
        st = -1;
        load_hex = h; load_dp = dp; load_en = en; load_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            done = (exp_q.size() == 0);
            if (done) st = FRAME * ((tn + 1) / FRAME + 1);
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic run_to(input int ph);
        for (int i = 0; i < FRAME && (tn % FRAME) != ph; i++) step();
    endtask

    task automatic test_reset();
        int st;
        do_reset(2);
        checks++; if (digit_sel !== 4'b0 || seg_out !== 7'b0 || dp_out !== 1'b0)
            begin errors++; $display("FAIL por_pins sel=%b seg=%b dp=%b want 0", digit_sel, seg_out, dp_out); end
        checks++; if (dec_hex !== 4'h0 || frame_start !== 1'b0 || load_ready !== 1'b1)
            begin errors++; $display("FAIL por_ctrl hex=%h fs=%b rdy=%b want 0/0/1", dec_hex, frame_start, load_ready); end
        load_frame(16'h1234, 4'b1111, 4'b1111, st);
        repeat (FRAME + 12) step();
        load_frame(16'hFEDC, 4'b0000, 4'b1111, st);
        repeat (5) step();
        do_reset(3);
        checks++; if (digit_sel !== 4'b0 || seg_out !== 7'b0 || dp_out !== 1'b0)
            begin errors++; $display("FAIL rst_pins sel=%b seg=%b dp=%b want 0", digit_sel, seg_out, dp_out); end
        checks++; if (dec_hex !== 4'h0 || frame_start !== 1'b0 || load_ready !== 1'b1)
            begin errors++; $display("FAIL rst_ctrl hex=%h fs=%b rdy=%b want 0/0/1", dec_hex, frame_start, load_ready); end
        for (int i = 0; i < FRAME + 16; i++) begin
            step();
            checks++; if (digit_sel !== 4'b0)
                begin errors++; $display("FAIL rst_dark tn=%0d sel=%b want 0000", tn, digit_sel); end
            checks++; if (load_ready !== 1'b1)
                begin errors++; $display("FAIL rst_ready tn=%0d rdy=%b want 1", tn, load_ready); end
        end
    endtask

    task automatic test_load_scan();
        int st;
        load_frame(16'h3A71, 4'b0100, 4'b1111, st);
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            checks++; if (digit_sel !== x_sel())
                begin errors++; $display("FAIL scan_sel tn=%0d got=%b want=%b", tn, digit_sel, x_sel()); end
            checks++; if (seg_out !== x_seg())
                begin errors++; $display("FAIL scan_seg tn=%0d got=%b want=%b", tn, seg_out, x_seg()); end
            checks++; if (dp_out !== x_dp())
                begin errors++; $display("FAIL scan_dp tn=%0d got=%b want=%b", tn, dp_out, x_dp()); end
            checks++; if (dec_hex !== x_hex())
                begin errors++; $display("FAIL scan_dechex tn=%0d got=%h want=%h", tn, dec_hex, x_hex()); end
            checks++; if (frame_start !== x_fs())
                begin errors++; $display("FAIL scan_fs tn=%0d got=%b want=%b", tn, frame_start, x_fs()); end
        end
    endtask

    task automatic test_enable_mask();
        int st, d;
        load_frame(16'h3A71, 4'b1111, 4'b1010, st);
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            step();
            d = ((tn - 1) / CLK_DIV) % DIGITS;
            checks++; if (digit_sel !== x_sel())
                begin errors++; $display("FAIL mask_sel tn=%0d got=%b want=%b", tn, digit_sel, x_sel()); end
            if (tn - 1 >= st) begin
                checks++; if (digit_sel === 4'b0001 || digit_sel === 4'b0100)
                    begin errors++; $display("FAIL mask_disabled tn=%0d got=%b want not 0001/0100", tn, digit_sel); end
                if (d == 0 || d == 2) begin
                    checks++; if (seg_out !== 7'b0 || dp_out !== 1'b0)
                        begin errors++; $display("FAIL mask_dark tn=%0d seg=%b dp=%b want 0", tn, seg_out, dp_out); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int  sa;
        bit  b_taken, now_taken;
        b_taken = 1'b0;
        run_to(5);
        load_frame(16'hC0DE, 4'b0001, 4'b1111, sa);
        load_hex = 16'h8E2B; load_dp = 4'b1000; load_en = 4'b0111; load_valid = 1'b1;
        for (int i = 0; i < 3 * FRAME + 8; i++) begin
            now_taken = !b_taken && (exp_q.size() == 0) && load_valid;
            step();
            if (now_taken) begin b_taken = 1'b1; load_valid = 1'b0; end
            checks++; if (load_ready !== x_rdy())
                begin errors++; $display("FAIL bp_ready tn=%0d got=%b want=%b", tn, load_ready, x_rdy()); end
            checks++; if (digit_sel !== x_sel())
                begin errors++; $display("FAIL bp_sel tn=%0d got=%b want=%b", tn, digit_sel, x_sel()); end
            checks++; if (seg_out !== x_seg() || dp_out !== x_dp())
                begin errors++; $display("FAIL bp_seg tn=%0d got=%b/%b want=%b/%b", tn, seg_out, dp_out, x_seg(), x_dp()); end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_boundary();
        run_to(FRAME - 1);
        load_hex = 16'hF000; load_dp = 4'b0000; load_en = 4'b1000; load_valid = 1'b1;
        checks++; if (load_ready !== 1'b1)
            begin errors++; $display("FAIL bnd_ready_at_wrap tn=%0d got=%b want=1", tn, load_ready); end
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            checks++; if (digit_sel !== x_sel())
                begin errors++; $display("FAIL bnd_sel tn=%0d got=%b want=%b", tn, digit_sel, x_sel()); end
            checks++; if (seg_out !== x_seg())
                begin errors++; $display("FAIL bnd_seg tn=%0d got=%b want=%b", tn, seg_out, x_seg()); end
            checks++; if (load_ready !== x_rdy())
                begin errors++; $display("FAIL bnd_ready tn=%0d got=%b want=%b", tn, load_ready, x_rdy()); end
            step();
        end
    endtask

    task automatic test_frame_start();
        int pulses, last;
        pulses = 0;
        last = -1;
        run_to(1);
        for (int i = 0; i < 5 * FRAME; i++) begin
            step();
            checks++; if (frame_start !== x_fs())
                begin errors++; $display("FAIL fs_level tn=%0d got=%b want=%b", tn, frame_start, x_fs()); end
            if (frame_start === 1'b1) begin
                if (last >= 0) begin
                    checks++; if (tn - last != FRAME)
                        begin errors++; $display("FAIL fs_spacing got=%0d want=%0d", tn - last, FRAME); end
                end
                last = tn;
                pulses++;
            end
        end
        checks++; if (pulses != 5)
            begin errors++; $display("FAIL fs_count got=%0d want=5", pulses); end
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_enable_mask();
        test_backpressure();
        test_boundary();
        test_frame_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
